fft_radix2_iter: RTL and testbench

FFT_RADIX2_ITER -- requirements
Module: fft_radix2_iter

---
 rtl/fft_radix2_iter.sv | 195 +++++++++++++++++++
 tb/tb_fft_radix2_iter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT, one butterfly per clock.
// Samples are written in bit-reversed order during LOAD, transformed in place
// during COMPUTE, and streamed out in natural order during UNLOAD.
// Optional build macro FFT_STAGE_SCALE_EN: halve (round half-up) every stage,
// giving DFT/N instead of the unscaled DFT.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | accepting N input samples
// COMPUTE | L*N/2 butterflies, one per cycle
// UNLOAD  | presenting N output bins with valid/ready
module fft_radix2_iter #(
  parameter int N  = 16,
  parameter int DW = 18
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*DW-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*DW-1:0]        out_data,
  output logic [$clog2(N)-1:0]   out_index,
  output logic                   busy,
  output logic                   done
);

  localparam int L = $clog2(N);
  localparam logic [L-1:0] LAST_IDX  = L'(N - 1);
  localparam logic [L-1:0] LAST_BFLY = L'(N / 2 - 1);
  localparam logic [L-1:0] LM1       = L'(L - 1);
  localparam logic [L-1:0] ONE_L     = L'(1);
  localparam logic signed [2*DW:0] RND = {{(DW + 2){1'b0}}, 1'b1, {(DW - 2){1'b0}}};

  // Twiddle table W_k = cos - j*sin, packed {re, im} per entry, W_0 re clamped to max positive.
  function automatic logic [N*DW-1:0] gen_tw();
    logic [N*DW-1:0] tbl;
    real ang, fs;
    integer cr, ci, wmax;
    tbl  = '0;
    fs   = 2.0 ** (DW - 1);
    wmax = (2 ** (DW - 1)) - 1;
    for (int k = 0; k < N / 2; k++) begin
      ang = 2.0 * 3.14159265358979323846 * k / N;
      cr  = $rtoi($floor($cos(ang) * fs + 0.5));
      ci  = $rtoi($floor(-$sin(ang) * fs + 0.5));
      if (cr > wmax) cr = wmax;
      if (ci > wmax) ci = wmax;
      tbl[k*2*DW +: 2*DW] = {DW'(cr), DW'(ci)};
    end
    return tbl;
  endfunction

  localparam logic [N*DW-1:0] TW_TBL = gen_tw();

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] x);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = x[L-1-i];
    return r;
  endfunction

  function automatic logic signed [2*DW:0] sx(input logic [DW-1:0] x);
    return {{(DW + 1){x[DW-1]}}, x};
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_e;

  state_e         state_q, state_d;
  logic [L-1:0]   cnt_q, cnt_d;
  logic [L-1:0]   stage_q, stage_d;
  logic           done_q, done_d;

  logic [2*DW-1:0] mem_q [N];
  logic [2*DW-1:0] tw_rom [N/2];

  logic [L-1:0]    p_idx, a_idx, q_idx;
  logic [L-2:0]    k_idx;
  logic [2*DW-1:0] a_val, b_val, w_val, wr_a, wr_q;
  logic signed [2*DW:0] pr_full, pi_full;
  logic [DW-1:0]   tr, ti;
  logic [DW:0]     sr, si, dr, di;

  for (genvar g = 0; g < N / 2; g++) begin : g_tw
    assign tw_rom[g] = TW_TBL[g*2*DW +: 2*DW];
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == UNLOAD);
  assign out_data  = out_valid ? mem_q[cnt_q] : '0;
  assign out_index = out_valid ? cnt_q : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // Butterfly addressing and arithmetic for the current (stage, butterfly) pair.
  always_comb begin
    p_idx   = cnt_q & ((ONE_L << stage_q) - ONE_L);
    a_idx   = ((cnt_q >> stage_q) << (stage_q + ONE_L)) | p_idx;
    q_idx   = a_idx | (ONE_L << stage_q);
    k_idx   = (L-1)'(p_idx << (LM1 - stage_q));
    a_val   = mem_q[a_idx];
    b_val   = mem_q[q_idx];
    w_val   = tw_rom[k_idx];
    pr_full = sx(b_val[2*DW-1:DW]) * sx(w_val[2*DW-1:DW])
            - sx(b_val[DW-1:0]) * sx(w_val[DW-1:0]) + RND;
    pi_full = sx(b_val[2*DW-1:DW]) * sx(w_val[DW-1:0])
            + sx(b_val[DW-1:0]) * sx(w_val[2*DW-1:DW]) + RND;
    tr = DW'(pr_full >>> (DW - 1));
    ti = DW'(pi_full >>> (DW - 1));
    sr = {a_val[2*DW-1], a_val[2*DW-1:DW]} + {tr[DW-1], tr};
    si = {a_val[DW-1], a_val[DW-1:0]} + {ti[DW-1], ti};
    dr = {a_val[2*DW-1], a_val[2*DW-1:DW]} - {tr[DW-1], tr};
    di = {a_val[DW-1], a_val[DW-1:0]} - {ti[DW-1], ti};
`ifdef FFT_STAGE_SCALE_EN
    // Keeping bits [DW:1] of (x+1) is an arithmetic halving with half-up rounding.
    wr_a = {DW'((sr + (DW+1)'(1)) >> 1), DW'((si + (DW+1)'(1)) >> 1)};
    wr_q = {DW'((dr + (DW+1)'(1)) >> 1), DW'((di + (DW+1)'(1)) >> 1)};
`else
    wr_a = {DW'(sr), DW'(si)};
    wr_q = {DW'(dr), DW'(di)};
`endif
  end

  // Sample memory: bit-reversed load writes, and both butterfly results on one edge.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && in_valid) mem_q[bitrev(cnt_q)] <= in_data;
    if (state_q == COMPUTE) begin
      mem_q[a_idx] <= wr_a;
      mem_q[q_idx] <= wr_q;
    end
  end

  // Control registers with asynchronous abort to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; cnt doubles as load index, butterfly index and output index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + ONE_L;
          if (cnt_q == LAST_IDX) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt_q == LAST_BFLY) begin
          cnt_d = '0;
          if (stage_q == LM1) begin
            stage_d = '0;
            state_d = UNLOAD;
          end else begin
            stage_d = stage_q + ONE_L;
          end
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          cnt_d = cnt_q + ONE_L;
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Directed bench for fft_radix2_iter (N=16, DW=18) with an expected-bin scoreboard.
module tb_fft_radix2_iter;
  localparam int N  = 16;
  localparam int DW = 18;
  localparam int L  = 4;
`ifdef FFT_STAGE_SCALE_EN
  localparam real AMP = 4096.0;
`else
  localparam real AMP = 65536.0;
`endif
  localparam logic [2*DW-1:0] JUNK = {18'd30000, 18'd12345};

  logic            clk;
  logic            reset_n;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_data;
  logic [L-1:0]    out_index;
  logic            busy;
  logic            done;

  typedef struct {
    int idx;
    int re;
    int im;
  } exp_t;

  exp_t            sb[$];
  logic [2*DW-1:0] xin [N];
  int              tests_run = 0;
  int              tests_failed = 0;

  fft_radix2_iter #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp);
    logic near;
    near = ((obs - exp) <= 2) && ((exp - obs) <= 2);
    tests_run++;
    assert (near === 1'b1) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d (+/-2)", tag, obs, exp);
    end
  endtask

  // kind 0: impulse at n=0, 1: DC 4096, 2: impulse at n=1
  task automatic set_stimulus(input int kind);
    real ang, re, im;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       xin[i] = (i == 0) ? {18'd65536, 18'd0} : '0;
        1:       xin[i] = {18'd4096, 18'd0};
        default: xin[i] = (i == 1) ? {18'd65536, 18'd0} : '0;
      endcase
    end
    for (int k = 0; k < N; k++) begin
      case (kind)
        0: begin re = AMP; im = 0.0; end
        1: begin re = (k == 0) ? AMP : 0.0; im = 0.0; end
        default: begin
          ang = 2.0 * 3.14159265358979323846 * k / N;
          re  = AMP * $cos(ang);
          im  = -AMP * $sin(ang);
        end
      endcase
      sb.push_back('{idx: k, re: $rtoi($floor(re + 0.5)), im: $rtoi($floor(im + 0.5))});
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the last accept.
  task automatic load_samples();
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = JUNK;
    @(negedge clk);
    start = 1'b0;
    check_eq("in_ready_in_load", 64'(in_ready), 64'(1));
    for (int i = 0; i < N; i++) begin
      if (i == 5) begin
        in_valid = 1'b0;
        in_data  = JUNK;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = xin[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic unload_run(input bit backpressure, input bit poke_start);
    int  lat;
    int  cyc;
    int  dones;
    bit  rdy;
    int  ore, oim;
    lat   = 0;
    dones = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (lat == 3) begin
        check_eq("busy_compute", 64'(busy), 64'(1));
        check_eq("in_ready_compute", 64'(in_ready), 64'(0));
        check_eq("out_data_idle_zero", 64'(out_data), 64'(0));
      end
      start = (poke_start && lat == 5);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_eq("first_out_latency", 64'(lat), 64'(32));
    cyc = 0;
    while (sb.size() > 0 && cyc < 200) begin
      rdy       = backpressure ? ((cyc % 2) == 1) : 1'b1;
      out_ready = rdy;
      start     = (poke_start && cyc == 4);
      if (out_valid === 1'b1) begin
        ore = $signed(out_data[2*DW-1:DW]);
        oim = $signed(out_data[DW-1:0]);
        check_eq($sformatf("out_index[%0d]", sb[0].idx), 64'(out_index), 64'(sb[0].idx));
        check_tol($sformatf("re[%0d]", sb[0].idx), ore, sb[0].re);
        check_tol($sformatf("im[%0d]", sb[0].idx), oim, sb[0].im);
        if (rdy) void'(sb.pop_front());
      end else begin
        check_eq("out_valid_in_unload", 64'(out_valid), 64'(1));
      end
      if (done === 1'b1) dones++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    start     = 1'b0;
    check_eq("scoreboard_drained", 64'(sb.size()), 64'(0));
    check_eq("done_after_last", 64'(done), 64'(1));
    check_eq("busy_after_last", 64'(busy), 64'(0));
    check_eq("out_valid_after_last", 64'(out_valid), 64'(0));
    check_eq("out_data_after_last", 64'(out_data), 64'(0));
    check_eq("out_index_after_last", 64'(out_index), 64'(0));
    if (done === 1'b1) dones++;
    @(negedge clk);
    check_eq("done_one_cycle", 64'(done), 64'(0));
    check_eq("done_pulse_count", 64'(dones), 64'(1));
  endtask

  initial begin
    reset_n   = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'(0));
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_out_data", 64'(out_data), 64'(0));
    check_eq("rst_out_index", 64'(out_index), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // in_valid while idle must be ignored
    in_valid = 1'b1;
    in_data  = JUNK;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_in_ready", 64'(in_ready), 64'(0));
      check_eq("idle_busy", 64'(busy), 64'(0));
    end
    in_valid = 1'b0;

    // impulse, with start pokes during compute and unload
    set_stimulus(0);
    load_samples();
    unload_run(1'b0, 1'b1);

    // DC
    set_stimulus(1);
    load_samples();
    unload_run(1'b0, 1'b0);

    // shifted impulse under alternating backpressure
    set_stimulus(2);
    load_samples();
    unload_run(1'b1, 1'b0);

    // abort in the middle of COMPUTE
    set_stimulus(2);
    sb.delete();
    load_samples();
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'(0));
    check_eq("abort_out_valid", 64'(out_valid), 64'(0));
    check_eq("abort_out_data", 64'(out_data), 64'(0));
    check_eq("abort_out_index", 64'(out_index), 64'(0));
    check_eq("abort_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    check_eq("abort_busy_next", 64'(busy), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // full transform after the abort
    set_stimulus(0);
    load_samples();
    unload_run(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
